// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix-keypad scanner.
// Frame decode classifies the 16 sampled key positions of one full scan.
package keypad_pkg;

    localparam int unsigned KEY_ROWS = 4;
    localparam int unsigned KEY_COLS = 4;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned KEYS     = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed,
        StRelease
    } key_state_e;

    typedef enum logic [1:0] {
        FrNone,
        FrSingle,
        FrMulti
    } frame_e;

    typedef struct packed {
        frame_e              kind;
        logic [CODE_W-1:0]   code;
    } frame_t;

    // Bit i of lows is key code i (row*4 + col); code is only meaningful for FrSingle.
    function automatic frame_t decode_frame(input logic [KEYS-1:0] lows);
        frame_t      res;
        int unsigned n;
        res.kind = FrNone;
        res.code = '0;
        n        = 0;
        for (int i = 0; i < KEYS; i++) begin
            if (lows[i]) begin
                if (n == 0) begin
                    res.code = CODE_W'(i);
                end
                n++;
            end
        end
        if (n == 1) begin
            res.kind = FrSingle;
        end else if (n > 1) begin
            res.kind = FrMulti;
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Row dwell timer: strobes on the last cycle of each row's dwell and marks
// the row-3 strobe as the end of a full frame.
module scan_tick #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       sample_strobe,
    output logic [1:0] row_idx,
    output logic       frame_end
);

    localparam int unsigned            CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0]       LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            row_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            row_q <= row_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sample_strobe = (cnt_q == LAST);
    assign row_idx       = row_q;
    assign frame_end     = sample_strobe && (row_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix-keypad scanner: drives active-low rows in turn, samples the
// synchronized columns, debounces whole frames and reports one event per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY  = 40_000_000,
    parameter int unsigned SCAN_HZ        = 2_000,
    parameter int unsigned DEBOUNCE_SCANS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        col_n,
    output logic [3:0]        row_n,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_held
);

    localparam int unsigned      DWELL    = CLK_FREQUENCY / SCAN_HZ;
    localparam int unsigned      DB_W     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS - 1);

    logic             sample_strobe;
    logic             frame_end;
    logic [1:0]       row_idx;

    logic [3:0]       col_meta_q;
    logic [3:0]       col_sync_q;
    logic [11:0]      acc_q;
    frame_t           frame;

    key_state_e        state_q, state_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    scan_tick #(
        .DWELL (DWELL)
    ) u_scan_tick (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .row_idx       (row_idx),
        .frame_end     (frame_end)
    );

    assign row_n = ~(4'b0001 << row_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Rows 0..2 are held here; row 3 is taken live at the frame-end strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (sample_strobe) begin
            unique case (row_idx)
                2'd0:    acc_q[3:0]  <= ~col_sync_q;
                2'd1:    acc_q[7:4]  <= ~col_sync_q;
                2'd2:    acc_q[11:8] <= ~col_sync_q;
                default: acc_q       <= acc_q;
            endcase
        end
    end

    assign frame = decode_frame({~col_sync_q, acc_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame.kind == FrSingle) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = StPressed;
                            code_d  = frame.code;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = StDebounce;
                            cand_d  = frame.code;
                            cnt_d   = DB_W'(1);
                        end
                    end
                end
                StDebounce: begin
                    if (frame.kind == FrSingle && frame.code == cand_q) begin
                        if (cnt_q == DB_LAST) begin
                            state_d = StPressed;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + DB_W'(1);
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    // Multi-key or a different key still counts as "not released".
                    if (frame.kind == FrNone) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StRelease;
                            cnt_d   = DB_W'(1);
                        end
                    end
                end
                StRelease: begin
                    if (frame.kind == FrNone) begin
                        if (cnt_q == DB_LAST) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + DB_W'(1);
                        end
                    end else begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed key scenarios plus random frames, checked
// every cycle against a frame-level debounce model of the keypad rules.
module tb_keypad_scanner;

    localparam int unsigned DS = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] keys;

    int compared   = 0;
    int mismatched = 0;

    // Frame-level reference model state.
    int          m_run;
    int          m_rel;
    logic [3:0]  m_cand;
    logic [3:0]  m_code;
    logic        m_held;
    logic        pend;

    keypad_scanner #(
        .CLK_FREQUENCY  (32),
        .SCAN_HZ        (8),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal keypad: a down key shorts its column to its row while that row is driven low.
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_rel  = 0;
        m_cand = '0;
        m_code = '0;
        m_held = 1'b0;
        pend   = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] k);
        int         n;
        logic [3:0] c;
        n = $countones(k);
        c = '0;
        for (int i = 15; i >= 0; i--) if (k[i]) c = 4'(i);
        if (!m_held) begin
            if (m_run > 0) begin
                if (n == 1 && c == m_cand) m_run++;
                else m_run = 0;
            end else if (n == 1) begin
                m_cand = c;
                m_run  = 1;
            end
            if (m_run == DS) begin
                pend   = 1'b1;
                m_code = m_cand;
                m_held = 1'b1;
                m_run  = 0;
                m_rel  = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel == DS) begin
                    m_held = 1'b0;
                    m_rel  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // Called at the negedge of a frame's first cycle; returns at the next frame's.
    task automatic run_frame(input logic [15:0] k);
        logic [3:0] exp_row;
        keys = k;
        for (int i = 0; i < 16; i++) begin
            exp_row = ~(4'b0001 << (i / 4));
            check("row_n", 16'(row_n), 16'(exp_row));
            check("key_valid", 16'(key_valid), (i == 0) ? 16'(pend) : 16'h0);
            check("key_code", 16'(key_code), 16'(m_code));
            check("key_held", 16'(key_held), 16'(m_held));
            @(negedge clk);
        end
        pend = 1'b0;
        model_frame(k);
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        for (int f = 0; f < n; f++) run_frame(k);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst_row_n", 16'(row_n), 16'h000e);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_held", 16'(key_held), 16'h0);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] v;
        v = '0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [15:0] k;
        int          sel;
        reset = 1'b1;
        keys  = '0;
        model_reset();
        @(negedge clk);

        // 1: reset values, then row rotation over idle frames.
        do_reset(2);
        run_frames('0, 2);

        // 2: key (2,1) held five frames, then released.
        run_frames(key_bit(2, 1), 5);
        check("t2_code", 16'(key_code), 16'd9);
        run_frames('0, 4);

        // 3: one-frame glitch on (2,1), then a stable (3,3).
        run_frame(key_bit(2, 1));
        run_frame('0);
        run_frames(key_bit(3, 3), 5);
        check("t3_code", 16'(key_code), 16'd15);
        run_frames('0, 4);

        // 4: two keys together never qualify; releasing one lets (0,0) through.
        run_frames(key_bit(0, 0) | key_bit(1, 1), 10);
        run_frames(key_bit(0, 0), 5);
        check("t4_held", 16'(key_held), 16'd1);
        run_frames('0, 4);

        // 5: long hold, short release bounce, then a real release and re-press.
        run_frames(key_bit(1, 2), 100);
        run_frame('0);
        run_frames(key_bit(1, 2), 5);
        run_frames('0, 3);
        run_frames(key_bit(1, 2), 5);
        check("t5_code", 16'(key_code), 16'd6);
        run_frames('0, 4);

        // 6: reset while two frames into debouncing (0,3); the key re-debounces from scratch.
        run_frames(key_bit(0, 3), 2);
        do_reset(1);
        run_frames(key_bit(0, 3), 5);
        check("t6_code", 16'(key_code), 16'd3);
        run_frames('0, 4);

        // Random frames: mostly repeating, with none / single / double patterns mixed in.
        k = '0;
        for (int f = 0; f < 80; f++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55) begin
                k = k;
            end else if (sel < 70) begin
                k = '0;
            end else if (sel < 92) begin
                k = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                k = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                  | key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            run_frame(k);
        end
        run_frames('0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
